mdu: RTL and testbench
======================

# mdu

Multiply/divide unit for the execute stage of the pipelined MIPS core. It runs `mult`, `multu`, `div` and `divu` as multi-cycle operations, handles `mthi` and `mtlo` writes, and holds the architectural HI/LO registers. Operands come from the E-stage forwarding muxes; operand `b` may carry the immediate extender's output. While `busy` is high, the hazard unit stalls any instruction that uses the MDU.

## Interface
- `MULT_CYCLES`, 5: cycles `busy` stays high for `mult` and `multu`.
- `DIV_CYCLES`, 10: cycles `busy` stays high for `div` and `divu`.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock, asynchronous and active-low.
- `start`  in  1  issue strobe, sampled on the rising edge.
- `mdu_op`  in  3  operation select: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 is reserved and treated as none.
- `a`  in  32  rs operand.
- `b`  in  32  rt operand, or the extended immediate.
- `busy`  out  1  high while a mult or div is in flight.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.

## Operation
- State machine with two states, IDLE and RUN; the RUN countdown uses a 4-bit counter `cnt`.
- IDLE with `start`=1:
  - op 1–4: compute the result and latch it into `hi_pend`/`lo_pend`, load `cnt` with the op latency, go to RUN.
  - op 5: `hi`←`a` at this edge; stay IDLE, `busy` stays 0.
  - op 6: `lo`←`a` at this edge; stay IDLE, `busy` stays 0.
  - op 0 or 7: no effect.
- RUN: decrement `cnt` every cycle. When `cnt`==1, commit `hi`←`hi_pend` and `lo`←`lo_pend`, and go to IDLE.
- `start` while in RUN is ignored, whatever the op. The hazard unit guarantees this never happens; the bench still checks that it is ignored.
- `hi` and `lo` hold their old values for the whole of RUN. There is no early visibility of results.
- mult: signed 32×32 product, 64 bits wide. HI = product[63:32], LO = product[31:0].
- multu: the same with both operands zero-extended.
- div:
  - signed division; the quotient truncates toward zero.
  - LO = quotient, HI = remainder; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (`b`==0, div or divu): `busy` goes high for `DIV_CYCLES` as normal, and HI/LO remain unchanged at the commit edge.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, state IDLE, `cnt`=0, pending registers 0.
- Reset asserted mid-RUN aborts the operation immediately. Nothing is committed, and after release the unit is in IDLE with HI=LO=0.
- `busy` is registered. It rises the cycle after the start edge and stays high for exactly `MULT_CYCLES` or `DIV_CYCLES` cycles.
- The commit edge is the same edge on which `busy` falls. New HI/LO values are readable in the first cycle `busy`=0.
- mthi/mtlo results are visible the cycle after the start edge, with no stall.
- Back-to-back issue: a new start is accepted in the first cycle `busy`=0.

## Structure
- Package `mdu_pkg`: op encodings (`MDU_NONE` … `MDU_MTLO`), state enum, and latency defaults.
- One sub-module, `mdu_arith`: combinational 64-bit product and 32-bit quotient/remainder, including the signedness handling and the divide-by-zero flag.
- The top level holds the FSM, the counter, and the pending and architectural registers.

## Test plan
- mult with a=0xFFFFFFFE (−2), b=3 -> `busy` high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu with a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- div with a=0xFFFFFFF9 (−7), b=2 -> 10 busy cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Separately, 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi with a=0x12345678 -> hi=0x12345678 next cycle, `busy` never rises. Then divu with b=0 -> 10 busy cycles, hi and lo unchanged.
- Start a mult, then at busy cycle 2 issue divu and also pulse mtlo -> both are ignored; only the mult result commits, after 5 cycles total.
- Assert `rst_n`=0 during busy cycle 3 of a div -> `busy`, `hi`, `lo` go to 0 immediately. After release, a new multu completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and default latencies.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic core: 64-bit product and 32-bit quotient/remainder,
// signed or unsigned, with a divide-by-zero flag.
module mdu_arith (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic [63:0] prod,
    output logic [31:0] quo,
    output logic [31:0] rem,
    output logic        dz
);

    logic [63:0] a_ext, b_ext;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag;

    always_comb begin
        a_ext = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
        b_ext = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
        // Low 64 bits of the extended product equal the signed product.
        prod  = a_ext * b_ext;

        // Magnitude-based division keeps 0x80000000 / -1 well defined.
        a_neg   = is_signed & a[31];
        b_neg   = is_signed & b[31];
        a_mag   = a_neg ? (32'd0 - a) : a;
        b_mag   = b_neg ? (32'd0 - b) : b;
        dz      = (b == '0);
        divisor = dz ? 32'd1 : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        quo     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem     = a_neg ? (32'd0 - r_mag) : r_mag;
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: issue FSM, latency counter, pending results and the
// architectural HI/LO registers.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_op_e    op;
    mdu_state_e state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [31:0] hi_pend, lo_pend;
    logic        dz_pend;

    logic        issue, commit, wr_hi, wr_lo;
    logic        is_mul, is_signed;
    logic [63:0] prod;
    logic [31:0] quo, rem, res_hi, res_lo;
    logic        dz, res_dz;

    assign op        = mdu_op_e'(mdu_op);
    assign is_mul    = (op == MDU_MULT) || (op == MDU_MULTU);
    assign is_signed = (op == MDU_MULT) || (op == MDU_DIV);

    mdu_arith u_arith (
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .prod      (prod),
        .quo       (quo),
        .rem       (rem),
        .dz        (dz)
    );

    always_comb begin
        res_hi = is_mul ? prod[63:32] : rem;
        res_lo = is_mul ? prod[31:0]  : quo;
        res_dz = !is_mul && dz;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        issue   = 1'b0;
        commit  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
                            issue   = 1'b1;
                            cnt_n   = 4'(MULT_CYCLES);
                            state_n = RUN;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            issue   = 1'b1;
                            cnt_n   = 4'(DIV_CYCLES);
                            state_n = RUN;
                        end
                        MDU_MTHI: wr_hi = 1'b1;
                        MDU_MTLO: wr_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    commit  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_pend <= '0;
            lo_pend <= '0;
            dz_pend <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (issue) begin
                hi_pend <= res_hi;
                lo_pend <= res_lo;
                dz_pend <= res_dz;
            end
            if (commit && !dz_pend) begin
                hi <= hi_pend;
                lo <= lo_pend;
            end
            if (wr_hi) hi <= a;
            if (wr_lo) lo <= a;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for the multiply/divide unit.
module tb_mdu;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mdu_op (mdu_op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        start  = 1'b1;
        mdu_op = op;
        a      = av;
        b      = bv;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mdu_op = OP_NONE;
    endtask

    // Counts busy cycles from now until busy drops (bounded) and tracks HI/LO stability.
    task automatic wait_idle(output int n, output bit held);
        logic [31:0] h0, l0;
        h0   = hi;
        l0   = lo;
        n    = 0;
        held = 1'b1;
        while (busy && n < 40) begin
            n++;
            if (hi !== h0 || lo !== l0) held = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
    endtask

    task automatic test_mult;
        int n; bit held;
        issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
        wait_idle(n, held);
        checks++; if (n !== 5) begin errors++; $display("FAIL mult_cycles: got %0d expected 5", n); end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL mult_early: got %b expected 1", held); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected FFFFFFFF", hi); end
        checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo: got %h expected FFFFFFFA", lo); end
    endtask

    task automatic test_multu;
        int n; bit held;
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle(n, held);
        checks++; if (n !== 5) begin errors++; $display("FAIL multu_cycles: got %0d expected 5", n); end
        checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h expected FFFFFFFE", hi); end
        checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
    endtask

    task automatic test_div;
        int n; bit held;
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_idle(n, held);
        checks++; if (n !== 10) begin errors++; $display("FAIL div_cycles: got %0d expected 10", n); end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL div_early: got %b expected 1", held); end
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h expected FFFFFFFD", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h expected FFFFFFFF", hi); end

        issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
        wait_idle(n, held);
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negb_lo: got %h expected FFFFFFFD", lo); end
        checks++; if (hi !== 32'h00000001) begin errors++; $display("FAIL div_negb_hi: got %h expected 00000001", hi); end

        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n, held);
        checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo); end
        checks++; if (hi !== 32'h00000000) begin errors++; $display("FAIL div_ovf_hi: got %h expected 00000000", hi); end

        issue(OP_DIVU, 32'd100, 32'd7);
        wait_idle(n, held);
        checks++; if (n !== 10) begin errors++; $display("FAIL divu_cycles: got %0d expected 10", n); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h expected 0000000e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h expected 00000002", hi); end
    endtask

    task automatic test_mthi_dz;
        int n; bit held;
        issue(OP_MTHI, 32'h12345678, 32'h0);
        checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi_hi: got %h expected 12345678", hi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b expected 0", busy); end
        issue(OP_MTLO, 32'hCAFEF00D, 32'h0);
        checks++; if (lo !== 32'hCAFEF00D) begin errors++; $display("FAIL mtlo_lo: got %h expected CAFEF00D", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy: got %b expected 0", busy); end

        issue(OP_DIVU, 32'd55, 32'd0);
        wait_idle(n, held);
        checks++; if (n !== 10) begin errors++; $display("FAIL divu0_cycles: got %0d expected 10", n); end
        checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL divu0_hi: got %h expected 12345678", hi); end
        checks++; if (lo !== 32'hCAFEF00D) begin errors++; $display("FAIL divu0_lo: got %h expected CAFEF00D", lo); end

        issue(OP_DIV, 32'hFFFFFFF0, 32'd0);
        wait_idle(n, held);
        checks++; if (n !== 10) begin errors++; $display("FAIL div0_cycles: got %0d expected 10", n); end
        checks++; if (hi !== 32'h12345678) begin errors++; $display("FAIL div0_hi: got %h expected 12345678", hi); end
        checks++; if (lo !== 32'hCAFEF00D) begin errors++; $display("FAIL div0_lo: got %h expected CAFEF00D", lo); end
    endtask

    task automatic test_ignore;
        int n; bit held;
        issue(OP_MULT, 32'd6, 32'd7);
        // busy cycle 1 now; step into busy cycle 2 and inject a divu
        @(posedge clk); #1;
        start = 1'b1; mdu_op = OP_DIVU; a = 32'd100; b = 32'd5;
        @(posedge clk); #1;
        mdu_op = OP_MTLO; a = 32'hDEADBEEF;
        @(posedge clk); #1;
        start = 1'b0; mdu_op = OP_NONE;
        wait_idle(n, held);
        checks++; if (n + 3 !== 5) begin errors++; $display("FAIL ignore_cycles: got %0d expected 5", n + 3); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL ignore_hi: got %h expected 00000000", hi); end
        checks++; if (lo !== 32'd42) begin errors++; $display("FAIL ignore_lo: got %h expected 0000002a", lo); end
        repeat (12) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_late_busy: got %b expected 0", busy); end
        checks++; if (lo !== 32'd42) begin errors++; $display("FAIL ignore_late_lo: got %h expected 0000002a", lo); end
    endtask

    task automatic test_back_to_back;
        int n; bit held;
        issue(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle(n, held);
        checks++; if (hi !== 32'd0 || lo !== 32'd1) begin errors++; $display("FAIL b2b_mult: got %h_%h expected 00000000_00000001", hi, lo); end
        issue(OP_DIVU, 32'hFFFFFFFF, 32'h10);
        wait_idle(n, held);
        checks++; if (n !== 10) begin errors++; $display("FAIL b2b_cycles: got %0d expected 10", n); end
        checks++; if (lo !== 32'h0FFFFFFF) begin errors++; $display("FAIL b2b_lo: got %h expected 0FFFFFFF", lo); end
        checks++; if (hi !== 32'h0000000F) begin errors++; $display("FAIL b2b_hi: got %h expected 0000000F", hi); end
    endtask

    task automatic test_reset_mid;
        int n; bit held;
        issue(OP_DIV, 32'd100, 32'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi: got %h expected 00000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo: got %h expected 00000000", lo); end
        #3;
        @(posedge clk);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL rstmid_after: got busy=%b hi=%h lo=%h expected 0/00000000/00000000", busy, hi, lo);
        end
        issue(OP_MULTU, 32'h00010000, 32'h00010000);
        wait_idle(n, held);
        checks++; if (n !== 5) begin errors++; $display("FAIL rstmid_multu_cycles: got %0d expected 5", n); end
        checks++; if (hi !== 32'd1 || lo !== 32'd0) begin errors++; $display("FAIL rstmid_multu: got %h_%h expected 00000001_00000000", hi, lo); end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        mdu_op = OP_NONE;
        a      = '0;
        b      = '0;
        #2;
        test_reset;
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset;
        test_mult;
        test_multu;
        test_div;
        test_mthi_dz;
        test_ignore;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
